// File: rtl/bg_arb_pkg.sv
// Shared definitions for the background ROM arbiter.
//   - bg_arb_state_e : query-port FSM states (IDLE, PEND, INFLIGHT)
//   - DEF_ADDR_W / DEF_DATA_W : default ROM address / word widths
//   - SCREEN_H / SCREEN_V : full-screen background dimensions
//   - cnt_width() : bits needed to hold a counter saturating at max_val
package bg_arb_pkg;

  localparam int unsigned SCREEN_H   = 640;
  localparam int unsigned SCREEN_V   = 480;
  localparam int unsigned ROM_WORDS  = SCREEN_H * SCREEN_V;
  localparam int unsigned DEF_ADDR_W = $clog2(ROM_WORDS);
  localparam int unsigned DEF_DATA_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    INFLIGHT = 2'd2
  } bg_arb_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bg_rom_lat_pipe.sv
// Owner-tag pipeline matching the ROM read latency.
// Each cycle the owner of the address on the ROM (query = 1, pixel = 0) enters the
// pipe; the tag leaves at the clock edge where that address's data is usable.
// Ports:
//   vga_clk, reset_n : pixel clock, async active-low reset (clears the pipe)
//   q_issue          : this cycle's ROM address belongs to the query port
//   pix_cap          : capture rom_q into pix_data at the coming edge
//   q_cap            : capture rom_q into q_data at the coming edge
//   q_valid          : registered one-cycle pulse following a query capture
module bg_rom_lat_pipe #(
  parameter int unsigned ROM_LAT = 1
) (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic q_issue,
  output logic pix_cap,
  output logic q_cap,
  output logic q_valid
);

  logic q_land;
  logic q_valid_q;

  // Data for an address issued in cycle n is usable at the edge closing cycle
  // n+ROM_LAT-1, so the tag needs ROM_LAT-1 delay stages before that edge.
  if (ROM_LAT > 1) begin : g_delay
    logic [ROM_LAT-2:0] tag_q;
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        tag_q <= '0;
      end else begin
        tag_q[0] <= q_issue;
        for (int i = 1; i < int'(ROM_LAT) - 1; i++) begin
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
    assign q_land = tag_q[ROM_LAT-2];
  end else begin : g_direct
    assign q_land = q_issue;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      q_valid_q <= 1'b0;
    end else begin
      q_valid_q <= q_land;
    end
  end

  assign pix_cap = ~q_land;
  assign q_cap   = q_land;
  assign q_valid = q_valid_q;

endmodule

// File: rtl/bg_rom_arbiter.sv
// Arbiter for the single read port of the full-screen background ROM.
// The VGA pixel fetch path owns the ROM whenever pix_active is high and in every
// cycle not granted to the game-logic query port. Queries use req/ack/valid.
// Ports:
//   vga_clk, reset_n      : pixel clock, async active-low reset
//   pix_active, pix_addr  : display enable and pixel fetch address
//   pix_data              : registered ROM word for the pixel path
//   q_req, q_addr         : query request (level) and address
//   q_ack                 : query address is on the ROM this cycle
//   q_valid, q_data       : query result pulse and held result
//   q_busy, q_starve      : query outstanding, query waited MAX_WAIT cycles
//   rom_addr, rom_q       : ROM read port
// Optional (macro BG_ARB_STATS_EN):
//   stat_clr              : synchronous clear of both statistics counters
//   stat_grants           : queries completed (saturating)
//   stat_stall            : cycles in PEND blocked by active video (saturating)
module bg_rom_arbiter
  import bg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 1023
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              pix_active,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  input  logic              q_req,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_ack,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic              q_busy,
  output logic              q_starve,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
`ifdef BG_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_grants,
  output logic [15:0]       stat_stall
`endif
);

  localparam int unsigned        WAIT_W    = cnt_width(MAX_WAIT);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  bg_arb_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WAIT_W-1:0] wait_q;
  logic              starve_q;
  logic [DATA_W-1:0] pix_data_q;
  logic [DATA_W-1:0] q_data_q;
  logic              grant;
  logic              pix_cap;
  logic              q_cap;
  logic              pipe_q_valid;

  // The pixel path always wins when video is active, even if it rises on the
  // very cycle a pending query could have been served.
  assign grant = (state_q == PEND) && !pix_active;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (q_req) begin
            state_q <= PEND;
            addr_q  <= q_addr;
            wait_q  <= '0;
          end
        end
        PEND: begin
          if (grant) begin
            state_q  <= INFLIGHT;
            starve_q <= 1'b0;
          end else begin
            if (wait_q != WAIT_MAX) begin
              wait_q <= wait_q + WAIT_W'(1);
            end
            // Set on the edge where the count lands on MAX_WAIT.
            if (wait_q >= WAIT_LAST) begin
              starve_q <= 1'b1;
            end
          end
        end
        INFLIGHT: begin
          // q_valid rises in the last latency cycle; q_req is ignored there.
          if (pipe_q_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bg_rom_lat_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_lat_pipe (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .q_issue (grant),
    .pix_cap (pix_cap),
    .q_cap   (q_cap),
    .q_valid (pipe_q_valid)
  );

  // Returns for query-owned addresses leave pix_data untouched.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_data_q <= '0;
      q_data_q   <= '0;
    end else begin
      if (pix_cap) begin
        pix_data_q <= rom_q;
      end
      if (q_cap) begin
        q_data_q <= rom_q;
      end
    end
  end

`ifdef BG_ARB_STATS_EN
  logic [15:0] grants_q;
  logic [15:0] stall_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else if (stat_clr) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      if (pipe_q_valid && (grants_q != 16'hFFFF)) begin
        grants_q <= grants_q + 16'd1;
      end
      if ((state_q == PEND) && pix_active && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign stat_grants = grants_q;
  assign stat_stall  = stall_q;
`endif

  assign rom_addr = grant ? addr_q : pix_addr;
  assign q_ack    = grant;
  assign q_valid  = pipe_q_valid;
  assign q_data   = q_data_q;
  assign q_busy   = (state_q != IDLE);
  assign q_starve = starve_q;
  assign pix_data = pix_data_q;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Self-checking bench for bg_rom_arbiter (ROM_LAT=1, MAX_WAIT=15).
// The ROM is modelled as returning the low address bits of rom_addr.
module tb_bg_rom_arbiter;

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DATA_W   = 2;
  localparam int unsigned ROM_LAT  = 1;
  localparam int unsigned MAX_WAIT = 15;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  logic  vga_clk    = 1'b0;
  logic  reset_n    = 1'b1;
  logic  pix_active = 1'b0;
  addr_t pix_addr   = '0;
  logic  q_req      = 1'b0;
  addr_t q_addr     = '0;
  data_t pix_data, q_data, rom_q;
  logic  q_ack, q_valid, q_busy, q_starve;
  addr_t rom_addr;
`ifdef BG_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_grants, stat_stall;
`endif

  always #5 vga_clk = ~vga_clk;

  assign rom_q = rom_addr[DATA_W-1:0];

  bg_rom_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ROM_LAT  (ROM_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .pix_active (pix_active),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .q_req      (q_req),
    .q_addr     (q_addr),
    .q_ack      (q_ack),
    .q_valid    (q_valid),
    .q_data     (q_data),
    .q_busy     (q_busy),
    .q_starve   (q_starve),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q)
`ifdef BG_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A query is "pending" from acceptance to grant and "in flight" until its
  // result has been presented; every ROM address schedules a return event.
  typedef struct {
    int    land;
    bit    is_q;
    data_t data;
  } ret_t;

  ret_t  rets[$];
  int    cyc;
  bit    m_pend, m_flight, m_valid, m_starve;
  int    m_wait;
  addr_t m_qaddr;
  data_t m_pix, m_qdata;

  function automatic data_t rom_val(input addr_t a);
    return a[DATA_W-1:0];
  endfunction

  task automatic model_reset();
    rets.delete();
    cyc = 0; m_pend = 0; m_flight = 0; m_valid = 0; m_starve = 0;
    m_wait = 0; m_qaddr = '0; m_pix = '0; m_qdata = '0;
  endtask

  task automatic model_edge();
    bit ack, accept, next_valid;
    ack    = m_pend && !pix_active;
    accept = !m_pend && !m_flight && q_req;
    rets.push_back('{cyc + int'(ROM_LAT) - 1, ack, rom_val(ack ? m_qaddr : pix_addr)});
    next_valid = 0;
    while (rets.size() > 0 && rets[0].land == cyc) begin
      ret_t r;
      r = rets.pop_front();
      if (r.is_q) begin
        m_qdata = r.data;
        next_valid = 1;
      end else begin
        m_pix = r.data;
      end
    end
    if (m_valid) m_flight = 0;
    m_valid = next_valid;
    if (ack) begin
      m_pend = 0; m_flight = 1; m_starve = 0;
    end else if (m_pend) begin
      if (m_wait < int'(MAX_WAIT)) m_wait++;
      if (m_wait == int'(MAX_WAIT)) m_starve = 1;
    end
    if (accept) begin
      m_pend = 1; m_qaddr = q_addr; m_wait = 0;
    end
    cyc++;
  endtask

  task automatic check_regs();
    chk("pix_data", pix_data, m_pix);
    chk("q_data", q_data, m_qdata);
    chk("q_valid", q_valid, m_valid);
    chk("q_busy", q_busy, m_pend || m_flight);
    chk("q_starve", q_starve, m_starve);
  endtask

  task automatic check_comb();
    bit ack;
    ack = m_pend && !pix_active;
    chk("q_ack", q_ack, ack);
    chk("rom_addr", rom_addr, ack ? m_qaddr : pix_addr);
  endtask

  // ---------------- cycle helpers ----------------
  task automatic drive(input logic pa, input addr_t pad, input logic rq, input addr_t qa);
    @(negedge vga_clk);
    check_regs();
    pix_active = pa; pix_addr = pad; q_req = rq; q_addr = qa;
    #1;
    check_comb();
  endtask

  task automatic tick();
    model_edge();
    @(posedge vga_clk);
  endtask

  task automatic step(input logic pa, input addr_t pad, input logic rq, input addr_t qa);
    drive(pa, pad, rq, qa);
    tick();
  endtask

  task automatic reset_now();
    reset_n = 1'b0;
    #1;
    chk("rst_pix_data", pix_data, 0);
    chk("rst_q_data", q_data, 0);
    chk("rst_q_ack", q_ack, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q_busy", q_busy, 0);
    chk("rst_q_starve", q_starve, 0);
    chk("rst_rom_addr", rom_addr, pix_addr);
`ifdef BG_ARB_STATS_EN
    chk("rst_stat_grants", stat_grants, 0);
    chk("rst_stat_stall", stat_stall, 0);
`endif
    pix_active = 1'b0; pix_addr = '0; q_req = 1'b0; q_addr = '0;
    model_reset();
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    tick();
  endtask

`ifdef BG_ARB_STATS_EN
  task automatic query(input addr_t a, input int nstall);
    step(1'b0, addr_t'($urandom), 1'b1, a);
    repeat (nstall) step(1'b1, addr_t'($urandom), 1'b0, '0);
    step(1'b0, addr_t'($urandom), 1'b0, '0);
    step(1'b0, addr_t'($urandom), 1'b0, '0);
  endtask
`endif

  // ---------------- directed table ----------------
  typedef struct {
    logic  pa;
    addr_t pad;
    logic  rq;
    addr_t qa;
    logic  e_ack;
    logic  e_valid;
    logic  e_busy;
    data_t e_qdata;
    data_t e_pix;
    addr_t e_rom;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic  pa_r;
    data_t pe;
    // Idle blanking: request at cycle 10, ack at 11, result at 12.
    for (int i = 0; i < 14; i++) begin
      if (i == 0) pe = 2'd0;
      else if (i == 12) pe = 2'd2;  // query return at 11 holds cycle-10 pixel
      else pe = data_t'((i - 1) % 4);
      tbl[i] = '{1'b0, addr_t'(i), (i == 10), 19'h12345, (i == 11), (i == 12),
                 (i == 11 || i == 12), (i >= 12) ? 2'b01 : 2'b00, pe,
                 (i == 11) ? 19'h12345 : addr_t'(i)};
    end

    #2;
    reset_now();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].pa, tbl[i].pad, tbl[i].rq, tbl[i].qa);
      chk($sformatf("tbl%0d_ack", i), q_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_valid", i), q_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_busy", i), q_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_qdata", i), q_data, tbl[i].e_qdata);
      chk($sformatf("tbl%0d_pix", i), pix_data, tbl[i].e_pix);
      chk($sformatf("tbl%0d_rom", i), rom_addr, tbl[i].e_rom);
      tick();
    end

    // Active video stall: 200 cycles of pix_active with a query waiting.
    step(1'b1, addr_t'($urandom), 1'b1, 19'h5A5A5);
    repeat (199) step(1'b1, addr_t'($urandom), 1'b0, addr_t'($urandom));
    drive(1'b0, addr_t'($urandom), 1'b0, '0);
    chk("stall_ack", q_ack, 1);
    chk("stall_rom", rom_addr, 19'h5A5A5);
    chk("stall_starve_held", q_starve, 1);
    tick();
    drive(1'b0, addr_t'($urandom), 1'b0, '0);
    chk("stall_starve_clr", q_starve, 0);
    chk("stall_valid", q_valid, 1);
    chk("stall_qdata", q_data, 2'b01);
    tick();

    // Starvation threshold: sticky from wait count 15.
    step(1'b0, '0, 1'b1, 19'h00002);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, addr_t'($urandom), 1'b0, '0);
      chk($sformatf("starve_k%0d", k), q_starve, k >= 16);
      tick();
    end
    drive(1'b0, addr_t'($urandom), 1'b0, '0);
    chk("starve_ack", q_ack, 1);
    tick();
    drive(1'b0, addr_t'($urandom), 1'b0, '0);
    chk("starve_after_ack", q_starve, 0);
    tick();

    // pix_data integrity with back-to-back grants during blanking.
    repeat (60) step(1'b0, addr_t'($urandom), 1'b1, addr_t'($urandom));

    // Randomized traffic with bursty display enable.
    pa_r = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 7) == 0) pa_r = ~pa_r;
      step(pa_r, addr_t'($urandom), ($urandom_range(0, 2) == 0), addr_t'($urandom));
    end
    repeat (6) step(1'b0, addr_t'($urandom), 1'b0, '0);

    // Async reset in the result cycle of a query.
    step(1'b0, 19'h00007, 1'b1, 19'h00003);
    step(1'b0, 19'h00005, 1'b0, '0);
    drive(1'b0, 19'h00006, 1'b0, '0);
    chk("pre_rst_valid", q_valid, 1);
    chk("pre_rst_qdata", q_data, 2'd3);
    reset_now();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, addr_t'($urandom), 1'b0, '0);
      chk($sformatf("post_rst_valid%0d", k), q_valid, 0);
      tick();
    end

`ifdef BG_ARB_STATS_EN
    @(negedge vga_clk);
    reset_now();
    query(19'h00011, 2);
    query(19'h00022, 5);
    query(19'h00033, 0);
    drive(1'b0, '0, 1'b0, '0);
    chk("stat_grants", stat_grants, 3);
    chk("stat_stall", stat_stall, 7);
    stat_clr = 1'b1;
    tick();
    drive(1'b0, '0, 1'b0, '0);
    stat_clr = 1'b0;
    chk("stat_grants_clr", stat_grants, 0);
    chk("stat_stall_clr", stat_stall, 0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bg_rom_arbiter.md
Name: bg_rom_arbiter

Overview:
- Shares the single read port of the full-screen background ROM (640x480 indices, 2-bit palette index) between two requesters.
- Requester 1 is the VGA pixel fetch path; it has absolute priority during active video.
- Requester 2 is a game-logic query port, e.g. collision or terrain lookup, served with a req/ack/valid handshake on cycles the pixel path does not need.
- Sits between the VGA controller / palette path and the ROM instance.

Parameters:
- ADDR_W, 19, ROM address width.
- DATA_W, 2, ROM word width (palette index).
- ROM_LAT, 1, cycles from rom_addr presented to rom_q usable at a vga_clk rising edge.
- MAX_WAIT, 1023, query wait cycles before q_starve asserts.

Ports:
- vga_clk in 1: pixel clock; all logic on rising edge.
- reset_n in 1: asynchronous, active-low reset.
- pix_active in 1: high during visible pixels (display enable from VGA controller).
- pix_addr in ADDR_W: pixel fetch address for the current cycle.
- pix_data out DATA_W: registered ROM word for the pixel path.
- q_req in 1: query request; level, sampled only in IDLE.
- q_addr in ADDR_W: query address; latched when q_req is accepted into PEND.
- q_ack out 1: one-cycle pulse; query address is on the ROM this cycle.
- q_valid out 1: one-cycle pulse; q_data is valid.
- q_data out DATA_W: query result, held until the next q_valid.
- q_busy out 1: high in PEND and INFLIGHT.
- q_starve out 1: sticky; high once wait count reaches MAX_WAIT, cleared on q_ack.
- rom_addr out ADDR_W: address to ROM.
- rom_q in DATA_W: ROM data.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - pix_data, q_data = 0.
  - q_ack, q_valid, q_busy, q_starve = 0.
  - Wait counter = 0; latency pipe cleared.
  - rom_addr follows pix_addr (combinational mux, default pixel owner).
- States:
  - IDLE → PEND on q_req=1; latch q_addr, clear wait counter.
  - PEND: query owns the ROM in any cycle where pix_active=0. That cycle: rom_addr = latched addr, q_ack=1, next state INFLIGHT. Otherwise increment wait counter, saturating at MAX_WAIT.
  - INFLIGHT: count ROM_LAT cycles, then capture rom_q into q_data, pulse q_valid, go to IDLE.
- Back-to-back queries:
  - q_req is not sampled in the cycle q_valid pulses.
  - Earliest re-accept is the cycle after q_valid, so minimum spacing is ROM_LAT+2 cycles per query.
- Ownership:
  - pix_active=1 always gives the pixel path the ROM, even mid-PEND.
  - INFLIGHT does not occupy the ROM; the pixel path owns it during INFLIGHT.
- pix_data:
  - Registers rom_q every cycle whose address ROM_LAT cycles earlier was pixel-owned.
  - Otherwise holds its value, so a query grant causes no glitch.
- Blanking prefetch: when pix_active=0 and no query grant, rom_addr = pix_addr, so the first visible pixel is prefetched.
- pix_active rising in the same cycle as a PEND grant opportunity: the pixel path wins; no q_ack.
- q_req deasserted while in PEND: ignored; the query completes (no cancel).
- q_starve: asserts the cycle the wait counter reaches MAX_WAIT; cleared on q_ack.
- Reset mid-operation: in-flight query is dropped; no q_valid after reset release.

Optional Feature:
- Macro BG_ARB_STATS_EN.
- When defined, adds these outputs:
  - stat_grants (16-bit): queries completed.
  - stat_stall (16-bit): cycles spent in PEND with pix_active=1.
- Both counters saturate and reset to 0.
- stat_clr input (1): synchronous clear, with priority over increment.
- When undefined: none of these ports or registers exist; behaviour is otherwise identical.

Decomposition:
- Package bg_arb_pkg:
  - state enum {IDLE, PEND, INFLIGHT}.
  - Default ADDR_W/DATA_W constants.
  - Screen constants: H=640, V=480.
- One sub-module, bg_rom_lat_pipe: ROM_LAT-deep shift register carrying the owner tag (pixel/query) per issued address. It drives the pix_data capture enable and q_valid.

Test Plan:
- Idle blanking: pix_active=0, q_req at cycle 10, q_addr=0x12345, rom model returns addr[1:0]. Expect q_ack at cycle 11, q_valid at cycle 12 (ROM_LAT=1), q_data=2'b01.
- Active video stall: q_req while pix_active=1 for 200 cycles. Expect no q_ack, rom_addr == pix_addr every cycle, q_ack on the first cycle pix_active=0.
- Starvation: MAX_WAIT=15, hold pix_active=1 for 20 cycles after q_req. Expect q_starve=1 from wait count 15, cleared with q_ack.
- pix_data integrity: alternate query grants during blanking. Expect pix_data unchanged on query-owned returns and correct for every pixel-owned address.
- Async reset in INFLIGHT: drop reset_n mid-query. Expect all outputs 0 immediately and no q_valid after release.
- BG_ARB_STATS_EN: 3 queries with 7 stall cycles. Expect stat_grants=3, stat_stall=7; stat_clr zeroes both.
